// File: rtl/deserializer_if.sv
// Bundle between the TSS byte-stream source, the deserializer and the command consumer.
//
// Signals:
//   tss_axis_tdata/tvalid/tlast  byte-wide AXI-Stream frame, driven by the link side
//   tss_axis_tready              byte accepted when high together with tvalid
//   cmd_o, cmd_len_o             reassembled command word and its length in bytes
//   cmd_valid_o / cmd_ready_i    command handshake towards the decoder
//   frame_err_o                  one-cycle pulse when a frame is dropped
//
// Modports:
//   master  link source plus command consumer (the environment around the deserializer)
//   slave   the deserializer itself
interface deserializer_if #(
  parameter int unsigned CMD_WIDTH = 272
);
  logic [7:0]           tss_axis_tdata;
  logic                 tss_axis_tvalid;
  logic                 tss_axis_tready;
  logic                 tss_axis_tlast;
  logic [CMD_WIDTH-1:0] cmd_o;
  logic [5:0]           cmd_len_o;
  logic                 cmd_valid_o;
  logic                 cmd_ready_i;
  logic                 frame_err_o;

  modport master (
    output tss_axis_tdata, tss_axis_tvalid, tss_axis_tlast, cmd_ready_i,
    input  tss_axis_tready, cmd_o, cmd_len_o, cmd_valid_o, frame_err_o
  );

  modport slave (
    input  tss_axis_tdata, tss_axis_tvalid, tss_axis_tlast, cmd_ready_i,
    output tss_axis_tready, cmd_o, cmd_len_o, cmd_valid_o, frame_err_o
  );
endinterface

// File: rtl/deserializer.sv
// Receive side of the TSS byte link. Reassembles a byte-wide AXI-Stream frame (header first,
// tlast on the final byte) into a wide command word and hands it to the command decoder over
// a valid/ready handshake. Frame length is selected by the header code; malformed frames are
// dropped and flagged with a one-cycle frame_err_o pulse.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    deserializer_if.slave: tss_axis_* byte input, cmd_o/cmd_len_o/cmd_valid_o/
//          cmd_ready_i command output, frame_err_o drop pulse
//
// Optional feature (macro DESER_TIMEOUT_EN): an inter-byte gap counter in COLLECT and DRAIN;
// a gap of TIMEOUT_CYCLES cycles drops the partial frame, pulses frame_err_o and returns to
// IDLE. Without the macro TIMEOUT_CYCLES is unused and those states wait indefinitely.
module deserializer #(
  parameter int unsigned CMD_WIDTH      = 272,
  parameter logic [7:0]  START_HDR      = 8'h01,
  parameter logic [7:0]  STOP_HDR       = 8'h02,
  parameter logic [7:0]  CONT_HDR       = 8'h04,
  parameter logic [7:0]  ABORT_HDR      = 8'h08,
  parameter int unsigned START_BYTES    = 34,
  parameter int unsigned STOP_BYTES     = 10,
  parameter int unsigned ABORT_BYTES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic          clk,
  input logic          rst_n,
  deserializer_if.slave bus
);

  localparam int unsigned NumBytes = CMD_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StCollect, StDrain, StHold} state_e;

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [5:0]           len_q, len_d;          // expected frame length of the current frame
  logic [5:0]           cmd_len_q, cmd_len_d;
  logic [CMD_WIDTH-1:0] asm_q, asm_d;
  logic                 err_q, err_d;

  logic       ready;
  logic       accept;
  logic [5:0] cnt_inc;
  logic       hdr_known;
  logic [5:0] hdr_len;

  assign ready   = (state_q != StHold);
  assign accept  = bus.tss_axis_tvalid && ready;
  assign cnt_inc = cnt_q + 6'd1;

  // Header code to frame length.
  always_comb begin
    hdr_known = 1'b1;
    hdr_len   = 6'(ABORT_BYTES);
    case (bus.tss_axis_tdata)
      START_HDR: hdr_len = 6'(START_BYTES);
      STOP_HDR:  hdr_len = 6'(STOP_BYTES);
      CONT_HDR:  hdr_len = 6'(STOP_BYTES);
      ABORT_HDR: hdr_len = 6'(ABORT_BYTES);
      default:   hdr_known = 1'b0;
    endcase
  end

`ifdef DESER_TIMEOUT_EN
  localparam int unsigned GapW = $clog2(TIMEOUT_CYCLES + 1);
  logic [GapW-1:0] gap_q, gap_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    cmd_len_d = cmd_len_q;
    asm_d     = asm_q;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          asm_d       = '0;
          asm_d[7:0]  = bus.tss_axis_tdata;
          cnt_d       = 6'd1;
          len_d       = hdr_len;
          if (!hdr_known) begin
            err_d = 1'b1;
            if (!bus.tss_axis_tlast) state_d = StDrain;
          end else if (bus.tss_axis_tlast) begin
            // Every known frame is at least two bytes long.
            err_d = 1'b1;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (accept) begin
          // Positions beyond the command width are counted but not stored.
          for (int unsigned k = 1; k < NumBytes; k++) begin
            if (cnt_q == 6'(k)) asm_d[8*k +: 8] = bus.tss_axis_tdata;
          end
          cnt_d = cnt_inc;
          if (bus.tss_axis_tlast) begin
            if (cnt_inc == len_q) begin
              state_d   = StHold;
              cmd_len_d = len_q;
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          end else if (cnt_inc == len_q) begin
            err_d   = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (accept && bus.tss_axis_tlast) state_d = StIdle;
      end
      StHold: begin
        if (bus.cmd_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef DESER_TIMEOUT_EN
    gap_d = '0;
    if ((state_q == StCollect || state_q == StDrain) && !accept) begin
      if (gap_q == GapW'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = StIdle;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      cmd_len_q <= '0;
      asm_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      cmd_len_q <= cmd_len_d;
      asm_q     <= asm_d;
      err_q     <= err_d;
    end
  end

`ifdef DESER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) gap_q <= '0;
    else        gap_q <= gap_d;
  end
`endif

  assign bus.tss_axis_tready = ready && rst_n;
  assign bus.cmd_o           = asm_q;
  assign bus.cmd_len_o       = cmd_len_q;
  assign bus.cmd_valid_o     = (state_q == StHold);
  assign bus.frame_err_o     = err_q;

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deserializer_if #(.CMD_WIDTH(272)) bus ();

  deserializer #(
    .CMD_WIDTH(272),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;
  int err_cnt = 0;
  int del_cnt = 0;

  // Count error pulses and delivered commands, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.frame_err_o === 1'b1) err_cnt++;
    if (bus.cmd_valid_o === 1'b1 && bus.cmd_ready_i === 1'b1) del_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and wait (bounded) for its handshake; returns 1 ns after that edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    bit done = 0;
    bus.tss_axis_tdata  = d;
    bus.tss_axis_tlast  = last;
    bus.tss_axis_tvalid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.tss_axis_tready === 1'b1) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    bus.tss_axis_tvalid = 1'b0;
    bus.tss_axis_tlast  = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL handshake_timeout: byte %h never accepted, tready=%b want 1", d,
               bus.tss_axis_tready);
    end
  endtask

  task automatic send_abort();
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.tss_axis_tready !== 1'b0)
      $display("FAIL rst_tready: got %b want 0", bus.tss_axis_tready); else passed++;
    checks++; if (bus.cmd_valid_o !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", bus.cmd_valid_o); else passed++;
    checks++; if (bus.cmd_len_o !== 6'd0)
      $display("FAIL rst_len: got %0d want 0", bus.cmd_len_o); else passed++;
    checks++; if (bus.cmd_o !== 272'd0)
      $display("FAIL rst_cmd: got %h want 0", bus.cmd_o); else passed++;
    checks++; if (bus.frame_err_o !== 1'b0)
      $display("FAIL rst_err: got %b want 0", bus.frame_err_o); else passed++;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.tss_axis_tready !== 1'b1)
      $display("FAIL rst_release_tready: got %b want 1", bus.tss_axis_tready); else passed++;
  endtask

  task automatic test_abort();
    int e0 = err_cnt;
    int d0 = del_cnt;
    bus.cmd_ready_i = 1'b1;
    send_abort();
    checks++; if (bus.cmd_valid_o !== 1'b1)
      $display("FAIL abort_valid: got %b want 1", bus.cmd_valid_o); else passed++;
    checks++; if (bus.cmd_o[15:0] !== 16'h0008)
      $display("FAIL abort_cmd: got %h want 0008", bus.cmd_o[15:0]); else passed++;
    checks++; if (bus.cmd_len_o !== 6'd2)
      $display("FAIL abort_len: got %0d want 2", bus.cmd_len_o); else passed++;
    checks++; if (bus.tss_axis_tready !== 1'b0)
      $display("FAIL abort_hold_tready: got %b want 0", bus.tss_axis_tready); else passed++;
    tick();
    checks++; if (bus.cmd_valid_o !== 1'b0 || bus.tss_axis_tready !== 1'b1)
      $display("FAIL abort_release: valid=%b tready=%b want 0/1", bus.cmd_valid_o,
               bus.tss_axis_tready); else passed++;
    checks++; if (err_cnt - e0 !== 0 || del_cnt - d0 !== 1)
      $display("FAIL abort_counts: errs=%0d dels=%0d want 0/1", err_cnt - e0, del_cnt - d0);
    else passed++;
  endtask

  task automatic test_header_tlast();
    send_byte(8'h08, 1'b1);
    checks++; if (bus.frame_err_o !== 1'b1 || bus.cmd_valid_o !== 1'b0)
      $display("FAIL hdr_tlast_err: err=%b valid=%b want 1/0", bus.frame_err_o,
               bus.cmd_valid_o); else passed++;
    tick();
    checks++; if (bus.frame_err_o !== 1'b0 || bus.tss_axis_tready !== 1'b1)
      $display("FAIL hdr_tlast_after: err=%b tready=%b want 0/1", bus.frame_err_o,
               bus.tss_axis_tready); else passed++;
  endtask

  task automatic test_start();
    logic [271:0] exp = '0;
    logic [271:0] held;
    bus.cmd_ready_i = 1'b0;
    exp[7:0] = 8'h01;
    for (int k = 1; k < 34; k++) exp[8*k +: 8] = 8'(k);
    send_byte(8'h01, 1'b0);
    for (int k = 1; k < 34; k++) begin
      tick();  // tvalid low for one cycle between bytes
      send_byte(8'(k), k == 33);
    end
    checks++; if (bus.cmd_valid_o !== 1'b1)
      $display("FAIL start_valid: got %b want 1", bus.cmd_valid_o); else passed++;
    checks++; if (bus.cmd_o !== exp)
      $display("FAIL start_cmd: got %h want %h", bus.cmd_o, exp); else passed++;
    checks++; if (bus.cmd_len_o !== 6'd34)
      $display("FAIL start_len: got %0d want 34", bus.cmd_len_o); else passed++;
    held = bus.cmd_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.cmd_valid_o !== 1'b1 || bus.tss_axis_tready !== 1'b0 || bus.cmd_o !== exp)
        $display("FAIL start_hold: cycle %0d valid=%b tready=%b want 1/0, cmd stable=%b", i,
                 bus.cmd_valid_o, bus.tss_axis_tready, bus.cmd_o === held);
      else passed++;
    end
    bus.cmd_ready_i = 1'b1;
    tick();
    checks++; if (bus.cmd_valid_o !== 1'b0 || bus.tss_axis_tready !== 1'b1)
      $display("FAIL start_release: valid=%b tready=%b want 0/1", bus.cmd_valid_o,
               bus.tss_axis_tready); else passed++;
    bus.cmd_ready_i = 1'b0;
  endtask

  task automatic test_truncated_stop();
    logic [271:0] exp = '0;
    int e0 = err_cnt;
    int d0 = del_cnt;
    bus.cmd_ready_i = 1'b1;
    send_byte(8'h02, 1'b0);
    for (int k = 1; k < 5; k++) send_byte(8'hA0 + 8'(k), k == 4);
    checks++; if (bus.frame_err_o !== 1'b1 || bus.cmd_valid_o !== 1'b0)
      $display("FAIL trunc_err: err=%b valid=%b want 1/0", bus.frame_err_o, bus.cmd_valid_o);
    else passed++;
    exp[7:0] = 8'h02;
    send_byte(8'h02, 1'b0);
    for (int k = 1; k < 10; k++) begin
      exp[8*k +: 8] = 8'h30 + 8'(k);
      send_byte(8'h30 + 8'(k), k == 9);
    end
    checks++; if (bus.cmd_valid_o !== 1'b1 || bus.cmd_len_o !== 6'd10)
      $display("FAIL stop_deliver: valid=%b len=%0d want 1/10", bus.cmd_valid_o,
               bus.cmd_len_o); else passed++;
    checks++; if (bus.cmd_o !== exp)
      $display("FAIL stop_cmd: got %h want %h", bus.cmd_o, exp); else passed++;
    tick();
    checks++; if (err_cnt - e0 !== 1 || del_cnt - d0 !== 1)
      $display("FAIL trunc_counts: errs=%0d dels=%0d want 1/1", err_cnt - e0, del_cnt - d0);
    else passed++;
  endtask

  task automatic test_unknown_header();
    int e0 = err_cnt;
    int d0 = del_cnt;
    bus.cmd_ready_i = 1'b1;
    send_byte(8'h55, 1'b0);
    checks++; if (bus.frame_err_o !== 1'b1)
      $display("FAIL unk_err: got %b want 1", bus.frame_err_o); else passed++;
    for (int k = 0; k < 3; k++) send_byte(8'h08, k == 2);
    checks++; if (bus.frame_err_o !== 1'b0 || bus.cmd_valid_o !== 1'b0)
      $display("FAIL unk_drain: err=%b valid=%b want 0/0", bus.frame_err_o, bus.cmd_valid_o);
    else passed++;
    tick();
    checks++; if (err_cnt - e0 !== 1 || del_cnt - d0 !== 0)
      $display("FAIL unk_counts: errs=%0d dels=%0d want 1/0", err_cnt - e0, del_cnt - d0);
    else passed++;
    send_abort();
    checks++; if (bus.cmd_valid_o !== 1'b1 || bus.cmd_o[15:0] !== 16'h0008)
      $display("FAIL unk_then_abort: valid=%b cmd=%h want 1/0008", bus.cmd_valid_o,
               bus.cmd_o[15:0]); else passed++;
    tick();
  endtask

  task automatic test_overlong_cont();
    int e0 = err_cnt;
    int d0 = del_cnt;
    bus.cmd_ready_i = 1'b1;
    send_byte(8'h04, 1'b0);
    for (int k = 1; k < 10; k++) send_byte(8'h40 + 8'(k), 1'b0);
    checks++; if (bus.frame_err_o !== 1'b1)
      $display("FAIL long_err_at10: got %b want 1", bus.frame_err_o); else passed++;
    send_byte(8'h4A, 1'b0);
    send_byte(8'h4B, 1'b1);
    checks++; if (bus.frame_err_o !== 1'b0 || bus.cmd_valid_o !== 1'b0)
      $display("FAIL long_drain: err=%b valid=%b want 0/0", bus.frame_err_o, bus.cmd_valid_o);
    else passed++;
    tick();
    checks++; if (err_cnt - e0 !== 1 || del_cnt - d0 !== 0 || bus.tss_axis_tready !== 1'b1)
      $display("FAIL long_counts: errs=%0d dels=%0d tready=%b want 1/0/1", err_cnt - e0,
               del_cnt - d0, bus.tss_axis_tready); else passed++;
  endtask

  task automatic test_reset_mid();
    int e0 = err_cnt;
    bus.cmd_ready_i = 1'b0;
    send_byte(8'h01, 1'b0);
    for (int k = 1; k < 10; k++) send_byte(8'(k), 1'b0);
    rst_n = 1'b0;
    tick();
    checks++; if (bus.tss_axis_tready !== 1'b0 || bus.cmd_valid_o !== 1'b0 ||
                  bus.cmd_o !== 272'd0 || bus.frame_err_o !== 1'b0)
      $display("FAIL midrst_outputs: tready=%b valid=%b err=%b cmd=%h want 0/0/0/0",
               bus.tss_axis_tready, bus.cmd_valid_o, bus.frame_err_o, bus.cmd_o);
    else passed++;
    rst_n = 1'b1;
    tick();
    bus.cmd_ready_i = 1'b1;
    send_abort();
    checks++; if (bus.cmd_valid_o !== 1'b1 || bus.cmd_len_o !== 6'd2 ||
                  bus.cmd_o !== 272'h0008)
      $display("FAIL midrst_next: valid=%b len=%0d cmd=%h want 1/2/0008", bus.cmd_valid_o,
               bus.cmd_len_o, bus.cmd_o); else passed++;
    tick();
    bus.cmd_ready_i = 1'b0;
    send_byte(8'h02, 1'b0);
    for (int k = 1; k < 10; k++) send_byte(8'h60 + 8'(k), k == 9);
    checks++; if (bus.cmd_valid_o !== 1'b1)
      $display("FAIL holdrst_pre: valid=%b want 1", bus.cmd_valid_o); else passed++;
    rst_n = 1'b0;
    tick();
    checks++; if (bus.cmd_valid_o !== 1'b0 || bus.cmd_len_o !== 6'd0 || bus.cmd_o !== 272'd0)
      $display("FAIL holdrst_outputs: valid=%b len=%0d cmd=%h want 0/0/0", bus.cmd_valid_o,
               bus.cmd_len_o, bus.cmd_o); else passed++;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.tss_axis_tready !== 1'b1 || err_cnt - e0 !== 0)
      $display("FAIL holdrst_after: tready=%b errs=%0d want 1/0", bus.tss_axis_tready,
               err_cnt - e0); else passed++;
  endtask

  task automatic test_back_to_back();
    int d0 = del_cnt;
    bus.cmd_ready_i = 1'b1;
    send_abort();
    send_abort();
    tick();
    checks++; if (del_cnt - d0 !== 2)
      $display("FAIL b2b_dels: got %0d want 2", del_cnt - d0); else passed++;
  endtask

`ifdef DESER_TIMEOUT_EN
  task automatic test_timeout();
    bus.cmd_ready_i = 1'b1;
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    repeat (15) tick();
    checks++; if (bus.frame_err_o !== 1'b0)
      $display("FAIL timeout_early: got %b want 0", bus.frame_err_o); else passed++;
    tick();
    checks++; if (bus.frame_err_o !== 1'b1)
      $display("FAIL timeout_pulse: got %b want 1", bus.frame_err_o); else passed++;
    send_abort();
    checks++; if (bus.cmd_valid_o !== 1'b1 || bus.cmd_len_o !== 6'd2)
      $display("FAIL timeout_next: valid=%b len=%0d want 1/2", bus.cmd_valid_o,
               bus.cmd_len_o); else passed++;
    tick();
  endtask
`endif

  initial begin
    bus.tss_axis_tdata  = 8'h00;
    bus.tss_axis_tvalid = 1'b0;
    bus.tss_axis_tlast  = 1'b0;
    bus.cmd_ready_i     = 1'b0;
    #1;
    test_reset();
    test_abort();
    test_header_tlast();
    test_start();
    test_truncated_stop();
    test_unknown_header();
    test_overlong_cont();
    test_reset_mid();
    test_back_to_back();
`ifdef DESER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
